// File: rtl/button_counter.sv
// button_counter
//   Three-button up/down/clear counter. Each raw button goes through a 2-flop
//   synchronizer and an independent debouncer; each debounced rising edge is
//   registered as a one-cycle press event that steps the count.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable clocks needed to accept a new level
//   MAX_VALUE       : upper count limit (1..255); up wraps to 0, down wraps here
//   HOLD_CYCLES     : hold time before the first autorepeat step
//   REPEAT_CYCLES   : interval between subsequent autorepeat steps
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   btn_up   : raw increment button, active-high
//   btn_down : raw decrement button, active-high
//   btn_clr  : raw clear button, active-high
//   data     : registered count 0..MAX_VALUE
//   upd      : one-cycle pulse in the cycle data takes a new value
//   wrap     : one-cycle pulse coincident with upd when the count wraps
//
// Build option
//   AUTOREPEAT_EN : when defined, a held up/down button repeats after
//                   HOLD_CYCLES and then every REPEAT_CYCLES.

module button_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000,
  parameter int unsigned MAX_VALUE       = 99,
  parameter int unsigned HOLD_CYCLES     = 500000,
  parameter int unsigned REPEAT_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  output logic [7:0] data,
  output logic       upd,
  output logic       wrap
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] MAXV = 8'(MAX_VALUE);

  // Bit 0 = up, bit 1 = down, bit 2 = clear.
  logic [2:0] raw;
  logic [2:0] press_v;
  logic [1:0] rep_v;

  assign raw = {btn_clr, btn_down, btn_up};

`ifdef AUTOREPEAT_EN
  localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
`else
  assign rep_v = '0;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic          s1, s2, deb, prs;
    logic [DW-1:0] cnt;
    logic          last;

    // Debounced level is about to toggle on this edge.
    assign last = (s2 != deb) && (cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        deb <= 1'b0;
        prs <= 1'b0;
        cnt <= '0;
      end else begin
        s1  <= raw[g];
        s2  <= s1;
        // Press is registered on the same edge the debounced level rises.
        prs <= last && !deb;
        if (s2 == deb) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt <= '0;
          deb <= ~deb;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press_v[g] = prs;

`ifdef AUTOREPEAT_EN
    if (g < 2) begin : g_rep
      logic          act, phase, rep;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] lim;

      assign lim = phase ? REP_LAST : HOLD_LAST;

      // A release on the same edge as a due repeat wins, so no step is
      // issued once the debounced level has started to fall.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          act   <= 1'b0;
          phase <= 1'b0;
          rep   <= 1'b0;
          rcnt  <= '0;
        end else begin
          rep <= 1'b0;
          if (last && !deb) begin
            act   <= 1'b1;
            phase <= 1'b0;
            rcnt  <= '0;
          end else if ((last && deb) || press_v[2]) begin
            act <= 1'b0;
          end else if (act) begin
            if (rcnt == lim) begin
              rep   <= 1'b1;
              phase <= 1'b1;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
      end

      assign rep_v[g] = rep;
    end
`endif
  end

  logic up_ev, dn_ev, clr_ev;

  assign up_ev  = press_v[0] | rep_v[0];
  assign dn_ev  = press_v[1] | rep_v[1];
  assign clr_ev = press_v[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      upd  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      upd  <= 1'b0;
      wrap <= 1'b0;
      if (clr_ev) begin
        if (data != '0) begin
          data <= '0;
          upd  <= 1'b1;
        end
      end else if (up_ev && dn_ev) begin
        // Opposing steps cancel.
      end else if (up_ev) begin
        upd <= 1'b1;
        if (data == MAXV) begin
          data <= '0;
          wrap <= 1'b1;
        end else begin
          data <= data + 8'd1;
        end
      end else if (dn_ev) begin
        upd <= 1'b1;
        if (data == '0) begin
          data <= MAXV;
          wrap <= 1'b1;
        end else begin
          data <= data - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_counter.sv
module tb_button_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_clr;
  logic [7:0] data;
  logic       upd, wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_counter #(
    .DEBOUNCE_CYCLES(4),
    .MAX_VALUE(99),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_clr(btn_clr),
    .data(data),
    .upd(upd),
    .wrap(wrap)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds the given buttons for 'hold' edges, releases, lets everything
  // settle, and reports what was seen on upd/wrap (cycle 1 = first edge
  // sampling the pressed level).
  task automatic do_press(input logic [2:0] btns, input int hold,
                          output int n_upd, output int n_wrap, output int n_stray,
                          output int first_upd, output int last_upd);
    n_upd = 0; n_wrap = 0; n_stray = 0; first_upd = -1; last_upd = -1;
    {btn_clr, btn_down, btn_up} = btns;
    for (int k = 1; k <= hold + 14; k++) begin
      if (k == hold + 1) {btn_clr, btn_down, btn_up} = 3'b000;
      tick();
      if (upd) begin
        n_upd++;
        if (first_upd < 0) first_upd = k;
        last_upd = k;
        if (wrap) n_wrap++;
      end else if (wrap) begin
        n_stray++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    tick(); tick();
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL reset_data actual=%0d expected=0", data); end
    checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd actual=%b expected=0", upd); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap actual=%b expected=0", wrap); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_press;
    logic [7:0] exp_d;
    logic       exp_u;
    btn_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_d = (k >= 7) ? 8'd1 : 8'd0;
      exp_u = (k == 7);
      checks++; if (data !== exp_d) begin failures++; $display("FAIL clean_data edge=%0d actual=%0d expected=%0d", k, data, exp_d); end
      checks++; if (upd !== exp_u) begin failures++; $display("FAIL clean_upd edge=%0d actual=%b expected=%b", k, upd, exp_u); end
      checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL clean_wrap edge=%0d actual=%b expected=0", k, wrap); end
    end
    btn_up = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL clean_release_upd actual=%b expected=0", upd); end
    end
    checks++; if (data !== 8'd1) begin failures++; $display("FAIL clean_final_data actual=%0d expected=1", data); end
  endtask

  task automatic test_glitch;
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      btn_up = (((k >> 1) & 1) == 0);
      tick();
      if (upd) n++;
    end
    btn_up = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (upd) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL glitch_upd_count actual=%0d expected=0", n); end
    checks++; if (data !== 8'd1) begin failures++; $display("FAIL glitch_data actual=%0d expected=1", data); end
  endtask

  task automatic test_wrap;
    int nu, nw, ns, f, l;
    do_press(3'b010, 8, nu, nw, ns, f, l);
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL down_to_zero_data actual=%0d expected=0", data); end
    checks++; if (nw !== 0) begin failures++; $display("FAIL down_to_zero_wrap actual=%0d expected=0", nw); end
    do_press(3'b010, 8, nu, nw, ns, f, l);
    checks++; if (data !== 8'd99) begin failures++; $display("FAIL down_wrap_pre_data actual=%0d expected=99", data); end
    do_press(3'b001, 8, nu, nw, ns, f, l);
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL up_wrap_data actual=%0d expected=0", data); end
    checks++; if (nu !== 1) begin failures++; $display("FAIL up_wrap_upd actual=%0d expected=1", nu); end
    checks++; if (nw !== 1) begin failures++; $display("FAIL up_wrap_wrap actual=%0d expected=1", nw); end
    checks++; if (ns !== 0) begin failures++; $display("FAIL up_wrap_stray actual=%0d expected=0", ns); end
    do_press(3'b010, 8, nu, nw, ns, f, l);
    checks++; if (data !== 8'd99) begin failures++; $display("FAIL down_wrap_data actual=%0d expected=99", data); end
    checks++; if (nw !== 1) begin failures++; $display("FAIL down_wrap_wrap actual=%0d expected=1", nw); end
    checks++; if (ns !== 0) begin failures++; $display("FAIL down_wrap_stray actual=%0d expected=0", ns); end
  endtask

  task automatic test_back_to_back;
    int nu, nw, ns, f, l, total;
    do_press(3'b011, 8, nu, nw, ns, f, l);
    checks++; if (nu !== 0) begin failures++; $display("FAIL updown_upd actual=%0d expected=0", nu); end
    checks++; if (data !== 8'd99) begin failures++; $display("FAIL updown_data actual=%0d expected=99", data); end
    do_press(3'b100, 8, nu, nw, ns, f, l);
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL clr99_data actual=%0d expected=0", data); end
    checks++; if (nu !== 1) begin failures++; $display("FAIL clr99_upd actual=%0d expected=1", nu); end
    total = 0;
    for (int i = 0; i < 42; i++) begin
      do_press(3'b001, 8, nu, nw, ns, f, l);
      total += nu;
    end
    checks++; if (data !== 8'd42) begin failures++; $display("FAIL up42_data actual=%0d expected=42", data); end
    checks++; if (total !== 42) begin failures++; $display("FAIL up42_upd actual=%0d expected=42", total); end
    do_press(3'b100, 8, nu, nw, ns, f, l);
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL clr42_data actual=%0d expected=0", data); end
    checks++; if (nu !== 1) begin failures++; $display("FAIL clr42_upd actual=%0d expected=1", nu); end
    checks++; if ((nw + ns) !== 0) begin failures++; $display("FAIL clr42_wrap actual=%0d expected=0", nw + ns); end
    do_press(3'b100, 8, nu, nw, ns, f, l);
    checks++; if (nu !== 0) begin failures++; $display("FAIL clr0_upd actual=%0d expected=0", nu); end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    btn_up = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    btn_up = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (upd) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL reset_mid_upd actual=%0d expected=0", n); end
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL reset_mid_data actual=%0d expected=0", data); end
  endtask

  task automatic test_reset_held;
    int nu, nw, ns, f, l;
    rst_n = 1'b0;
    btn_up = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    do_press(3'b001, 10, nu, nw, ns, f, l);
    checks++; if (nu !== 1) begin failures++; $display("FAIL held_reset_upd actual=%0d expected=1", nu); end
    checks++; if (f !== 7) begin failures++; $display("FAIL held_reset_latency actual=%0d expected=7", f); end
    checks++; if (data !== 8'd1) begin failures++; $display("FAIL held_reset_data actual=%0d expected=1", data); end
    // Reset between clock edges must clear the count immediately.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL async_reset_data actual=%0d expected=0", data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_autorepeat;
    int nu, nw, ns, f, l;
    int exp_n, exp_l;
`ifdef AUTOREPEAT_EN
    exp_n = 6; exp_l = 59;
`else
    exp_n = 1; exp_l = 7;
`endif
    do_press(3'b001, 60, nu, nw, ns, f, l);
    checks++; if (data !== 8'(exp_n)) begin failures++; $display("FAIL hold60_data actual=%0d expected=%0d", data, exp_n); end
    checks++; if (nu !== exp_n) begin failures++; $display("FAIL hold60_upd actual=%0d expected=%0d", nu, exp_n); end
    checks++; if (f !== 7) begin failures++; $display("FAIL hold60_first actual=%0d expected=7", f); end
    checks++; if (l !== exp_l) begin failures++; $display("FAIL hold60_last actual=%0d expected=%0d", l, exp_l); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_reset_held();
    test_autorepeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_counter.md
BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2000, meaning the number of consecutive stable clocks needed to accept a new button level.
REQ-002 SHALL have parameter MAX_VALUE, default 99, meaning the upper count limit; legal range 1..255.
REQ-003 SHALL have parameters HOLD_CYCLES (default 500000) and REPEAT_CYCLES (default 100000), meaning the autorepeat timing; they are used only under REQ-020.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_up, input, 1 bit: raw asynchronous increment button, active-high.
REQ-007 SHALL have port btn_down, input, 1 bit: raw asynchronous decrement button, active-high.
REQ-008 SHALL have port btn_clr, input, 1 bit: raw asynchronous clear button, active-high.
REQ-009 SHALL have port data, output, 8 bits: registered binary count 0..MAX_VALUE; it drives the data input of the downstream BCD display stage.
REQ-010 SHALL have port upd, output, 1 bit: one-cycle pulse in the same cycle that data takes a new value.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse, coincident with upd, when the count wraps in either direction.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer followed by an independent debouncer.
REQ-013 Debouncer SHALL keep a counter that clears whenever the synchronized level equals the debounced level and increments otherwise; the debounced level SHALL toggle on the cycle after the counter reaches DEBOUNCE_CYCLES-1.
REQ-014 SHALL register a one-cycle press event on each debounced 0->1 transition; release SHALL produce no event.
REQ-015 Latency: with a clean input level change, data/upd SHALL update exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the new raw level.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event and SHALL restart the stability count.
REQ-017 Step priority SHALL be: clr event, then simultaneous up+down events (no change, no upd), then up, then down.
REQ-018 Each up event SHALL give data+1; up at MAX_VALUE SHALL give 0 with wrap=1. Each down event SHALL give data-1; down at 0 SHALL give MAX_VALUE with wrap=1.
REQ-019 A clr event SHALL set data to 0 and pulse upd only if data was nonzero; wrap SHALL stay 0.

Configuration
REQ-020 When AUTOREPEAT_EN is defined, a debounced up or down level held for HOLD_CYCLES after its press event SHALL generate an additional step, then one more every REPEAT_CYCLES while held. Release, a clr event or reset SHALL cancel repeating. Without AUTOREPEAT_EN, exactly one step SHALL occur per press and the repeat counters SHALL be absent.

Reset
REQ-021 While rst_n=0: data=0, upd=0, wrap=0, all synchronizer and debounced levels = 0, and all debounce and repeat counters = 0, asynchronously.
REQ-022 A button already held at reset release SHALL be debounced as a new press and produce one event.
REQ-023 Reset asserted mid-debounce SHALL discard the pending transition.

Verification
REQ-024 Use DEBOUNCE_CYCLES=4, MAX_VALUE=99, HOLD_CYCLES=20, REPEAT_CYCLES=8.
REQ-025 The bench SHALL cover these directed scenarios:
- Clean btn_up press held 10 cycles -> data 0->1 at edge 7, upd pulse 1 cycle, wrap=0.
- btn_up toggling every 2 cycles for 40 cycles -> data unchanged, upd never asserted.
- data=99, one up press -> data=0, upd=1 and wrap=1 in the same cycle; then one down press -> data=99, wrap=1.
- up and down pressed on the same edge -> no change, no upd; data=42 then clr press -> data=0, upd=1, wrap=0.
- rst_n low for 1 cycle mid-debounce of an up press, button released before the reset ends -> data stays 0, no upd.
- AUTOREPEAT_EN defined, up held 60 cycles from data=0 -> steps at press, +20, +28, +36, ... giving data=6 at release; without the macro -> data=1.
